fifo_rx_port: RTL and testbench
===============================

# fifo_rx_port

Receiving end of the router's RTS/DCTS link handshake, placed at each router input port (N, E, W, S, L). The upstream sender raises RTS with a flit on `RX`. This block answers with a one-cycle CTS pulse, which is the sender's DCTS, and captures the flit into a small circular FIFO. It then presents the head flit to the local routing and arbitration logic, which pops it with `read_en`.

## Interface
- `DATA_WIDTH`, default 32, flit width in bits.
- `DEPTH`, default 4, FIFO entries; must be a power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `DRTS` in 1: upstream RTS; flit on `RX` is valid while high.
- `RX` in DATA_WIDTH: incoming flit.
- `CTS` out 1: clear-to-send, registered; wired to the upstream DCTS.
- `read_en` in 1: pop head flit this cycle.
- `Data_out` out DATA_WIDTH: head flit (show-ahead).
- `empty` out 1: FIFO holds 0 flits.
- `full` out 1: FIFO holds DEPTH flits.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- **Handshake FSM:** two states, `IDLE` (CTS=0) and `ACK` (CTS=1).
  - `IDLE` goes to `ACK` when DRTS=1 and count<DEPTH (occupancy sampled in that cycle).
  - `ACK` always returns to `IDLE` after exactly one cycle. CTS is never high on two consecutive cycles.
- **Write:** a write occurs on the rising edge where DRTS=1 and CTS=1. `RX` goes into `mem[wr_ptr]` and wr_ptr increments.
  - This matches the sender's transfer condition (RTS & DCTS). The sender drops RTS the next cycle and may re-raise it one cycle later.
- If DRTS falls while CTS=1 (protocol violation), no write occurs. FSM still returns to `IDLE`.
- **Read:** on an edge with read_en=1 and empty=0, rd_ptr increments. read_en while empty is ignored; pointers and count do not change.
- **Pointers:** binary, $clog2(DEPTH) bits, wrap from DEPTH-1 to 0 naturally.
- **Count:**
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write and read.
  - Clamped to range 0..DEPTH.
- **Status:** `empty` = (count==0), `full` = (count==DEPTH), both combinational from count. `Data_out` = `mem[rd_ptr]` combinationally.
- **Full gating:** the gate is count<DEPTH at the moment CTS rises, so a write can never hit a full FIFO. The sender's RTS simply stalls until a read frees a slot.
- **Reset (rst=0, asynchronous):**
  - CTS=0, FSM=`IDLE`, wr_ptr=rd_ptr=0, count=0.
  - empty=1, full=0, all mem entries=0, so Data_out=0.
  - A reset mid-handshake discards the in-flight flit. The sender's RTS simply sees no DCTS.

## Timing
- **DRTS to CTS:** DRTS sampled high at edge k (FIFO not full) gives CTS=1 during cycle k+1. The flit is written at edge k+1.
- **Write to output:** a flit is visible on `Data_out` and empty=0 in the cycle after the write edge, i.e. one cycle after capture.
- **Back-to-back flits:** peak throughput is one flit per 3 cycles under the sender's protocol: RTS high, CTS pulse, RTS low, repeat.
- **Full release:** when full, a read at edge r lets CTS rise at the earliest at edge r+1, provided DRTS=1.
- **Read:** read_en takes effect at the same edge. The next flit appears on `Data_out` the following cycle.

## Structure
- Shared package `noc_pkg`:
  - default `DATA_WIDTH`, `DEPTH`;
  - typedef `flit_t` (logic [DATA_WIDTH-1:0]);
  - enum `rx_hs_state_t` {`IDLE`, `ACK`}.
  - The arbiter's one-hot state constants move here too.
- One sub-module, `rts_cts_rx_ctrl`: the 2-state CTS FSM and write-enable generation.
- Storage, pointers and count stay in the top `fifo_rx_port`.

## Test plan
- **Reset:** drive rst=0 mid-operation with count=2 -> immediately CTS=0, count=0, empty=1, Data_out=0.
- **Single transfer:**
  - Stimulus: DRTS=1, RX=32'hA5A5_0001 at edge 0, held until CTS observed.
  - Required: CTS=1 in cycle 1 only, count=1 after edge 1, Data_out=32'hA5A5_0001.
- **Fill to full:**
  - Stimulus: 4 sender-protocol transfers (0x10..0x13) with read_en=0.
  - Required: full=1, count=4. A further DRTS held for 10 cycles yields CTS=0 throughout.
- **Release from full:**
  - Stimulus: from full with DRTS=1, pulse read_en one cycle.
  - Required: Data_out changes 0x10 to 0x11, CTS pulses exactly one cycle later, the new flit lands in the freed slot, and count returns to 4.
- **Wrap and order:**
  - Stimulus: push 10 flits (0x20..0x29) with interleaved reads so pointers wrap twice.
  - Required: pops emerge in order 0x20..0x29; on a simultaneous write+read edge, count is unchanged.
- **Abnormal inputs:**
  - read_en on empty -> count stays 0, no pointer movement.
  - DRTS dropped in the CTS cycle -> no write, count unchanged.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router definitions: default flit geometry, handshake state encoding
// and the arbiter's one-hot port-grant constants.
package noc_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;
  localparam int unsigned NOC_DEPTH      = 4;

  typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_hs_state_t;

  // One-hot grant encoding used by the output-port arbiter
  localparam logic [4:0] ARB_N = 5'b00001;
  localparam logic [4:0] ARB_E = 5'b00010;
  localparam logic [4:0] ARB_W = 5'b00100;
  localparam logic [4:0] ARB_S = 5'b01000;
  localparam logic [4:0] ARB_L = 5'b10000;

endpackage

// File: rtl/fifo_rx_port_if.sv
// Signals of one router input port: the upstream RTS/DCTS link and the
// local head-of-queue read side.
interface fifo_rx_port_if #(
  parameter int unsigned DATA_WIDTH = noc_pkg::NOC_DATA_WIDTH,
  parameter int unsigned DEPTH      = noc_pkg::NOC_DEPTH
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  DRTS;
  logic [DATA_WIDTH-1:0] RX;
  logic                  CTS;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;

  // Master drives the link and pops; slave is the receiving port
  modport master (
    output DRTS, RX, read_en,
    input  CTS, Data_out, empty, full, count
  );

  modport slave (
    input  DRTS, RX, read_en,
    output CTS, Data_out, empty, full, count
  );
endinterface

// File: rtl/rts_cts_rx_ctrl.sv
// Two-state CTS responder: one CTS pulse per accepted RTS, and the write
// strobe for the flit handed over during that pulse.
module rts_cts_rx_ctrl
  import noc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_drts,
  input  logic i_room,
  output logic o_cts,
  output logic o_wr_en_c
);

  rx_hs_state_t r_state;
  rx_hs_state_t w_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // ACK lasts exactly one cycle, so CTS can never stay high
  always_comb begin
    w_next    = IDLE;
    o_wr_en_c = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_drts && i_room) w_next = ACK;
      end
      ACK: begin
        w_next    = IDLE;
        o_wr_en_c = i_drts;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_cts = (r_state == ACK);

endmodule

// File: rtl/fifo_rx_port.sv
// Router input port: answers upstream RTS with a CTS pulse and buffers the
// received flits in a show-ahead circular FIFO.
module fifo_rx_port
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int unsigned DEPTH      = NOC_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  fifo_rx_port_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_room;
  logic w_cts;
  logic w_wr;
  logic w_rd;

  assign w_room = (r_count < CNT_W'(DEPTH));
  assign w_rd   = bus.read_en && (r_count != '0);

  rts_cts_rx_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_drts    (bus.DRTS),
    .i_room    (w_room),
    .o_cts     (w_cts),
    .o_wr_en_c (w_wr)
  );

  // Storage is cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.RX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   if (r_count < CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
        2'b01:   if (r_count != '0)           r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.CTS      = w_cts;
  assign bus.Data_out = r_mem[r_rd_ptr];
  assign bus.empty    = (r_count == '0);
  assign bus.full     = (r_count == CNT_W'(DEPTH));
  assign bus.count    = r_count;

endmodule

// File: tb/tb_fifo_rx_port.sv
// Directed bench for fifo_rx_port: drives the sender side of the RTS/DCTS
// link and the local pop, checking against hand-computed expectations.
module tb_fifo_rx_port;
  import noc_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fifo_rx_port_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  fifo_rx_port #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sender protocol: RTS until CTS seen, transfer edge, RTS low one cycle
  task automatic send_flit(input flit_t data);
    bit got;
    got = 1'b0;
    bus.DRTS = 1'b1;
    bus.RX   = data;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      if (bus.CTS === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_cts_timeout: flit %h saw no CTS within 8 cycles", data);
    end
    tick();
    bus.DRTS = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.CTS, bus.empty, bus.full, bus.count} !== {1'b0, 1'b1, 1'b0, 3'd0} || bus.Data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_por: cts=%b empty=%b full=%b count=%0d dout=%h, required 0 1 0 0 00000000",
               bus.CTS, bus.empty, bus.full, bus.count, bus.Data_out);
    end
    send_flit(32'h0000_0001);
    send_flit(32'h0000_0002);
    n_checks++;
    if (bus.count !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_pre_count: got %0d required 2", bus.count);
    end
    bus.DRTS = 1'b1;
    bus.RX   = 32'h0000_0003;
    tick();
    n_checks++;
    if (bus.CTS !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_cts: got %b required 1", bus.CTS);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.CTS, bus.empty, bus.full, bus.count} !== {1'b0, 1'b1, 1'b0, 3'd0} || bus.Data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: cts=%b empty=%b full=%b count=%0d dout=%h, required 0 1 0 0 00000000",
               bus.CTS, bus.empty, bus.full, bus.count, bus.Data_out);
    end
    bus.DRTS = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: count=%0d empty=%b, required 0 1", bus.count, bus.empty);
    end
  endtask

  task automatic test_single_transfer();
    bus.DRTS = 1'b1;
    bus.RX   = 32'hA5A5_0001;
    tick();
    n_checks++;
    if (bus.CTS !== 1'b1 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cts_cycle: cts=%b count=%0d empty=%b, required 1 0 1", bus.CTS, bus.count, bus.empty);
    end
    tick();
    bus.DRTS = 1'b0;
    n_checks++;
    if (bus.CTS !== 1'b0 || bus.count !== 3'd1 || bus.empty !== 1'b0 || bus.Data_out !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_after_write: cts=%b count=%0d empty=%b dout=%h, required 0 1 0 a5a50001",
               bus.CTS, bus.count, bus.empty, bus.Data_out);
    end
    tick();
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    n_checks++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop: empty=%b count=%0d, required 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_fill_full();
    int cts_hi;
    for (int i = 0; i < 4; i++) send_flit(flit_t'(32'h10 + i));
    n_checks++;
    if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.Data_out !== 32'h10) begin
      n_fail++;
      $display("FAIL fill_full: full=%b count=%0d dout=%h, required 1 4 00000010", bus.full, bus.count, bus.Data_out);
    end
    bus.DRTS = 1'b1;
    bus.RX   = 32'h14;
    cts_hi   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.CTS !== 1'b0) cts_hi++;
    end
    n_checks++;
    if (cts_hi !== 0 || bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_stall: cts high %0d cycles count=%0d, required 0 cycles count 4", cts_hi, bus.count);
    end
  endtask

  task automatic test_release_full();
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    n_checks++;
    if (bus.Data_out !== 32'h11 || bus.count !== 3'd3 || bus.CTS !== 1'b0) begin
      n_fail++;
      $display("FAIL release_read: dout=%h count=%0d cts=%b, required 00000011 3 0", bus.Data_out, bus.count, bus.CTS);
    end
    tick();
    n_checks++;
    if (bus.CTS !== 1'b1) begin
      n_fail++;
      $display("FAIL release_cts: got %b required 1", bus.CTS);
    end
    tick();
    bus.DRTS = 1'b0;
    n_checks++;
    if (bus.CTS !== 1'b0 || bus.count !== 3'd4 || bus.full !== 1'b1) begin
      n_fail++;
      $display("FAIL release_refill: cts=%b count=%0d full=%b, required 0 4 1", bus.CTS, bus.count, bus.full);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.Data_out !== flit_t'(32'h11 + i)) begin
        n_fail++;
        $display("FAIL release_drain[%0d]: got %h required %h", i, bus.Data_out, 32'h11 + i);
      end
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
    end
    n_checks++;
    if (bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL release_empty: got %b required 1", bus.empty);
    end
  endtask

  task automatic test_wrap_order();
    flit_t q[$];
    int    exp_cnt;
    bit    got;
    bit    popped;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.DRTS = 1'b1;
      bus.RX   = flit_t'(32'h20 + i);
      got      = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        if (bus.CTS === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL wrap_cts_timeout[%0d]: no CTS within 8 cycles", i);
      end
      popped = 1'b0;
      if (exp_cnt >= 2) begin
        n_checks++;
        if (bus.Data_out !== q[0]) begin
          n_fail++;
          $display("FAIL wrap_pop[%0d]: got %h required %h", i, bus.Data_out, q[0]);
        end
        bus.read_en = 1'b1;
        popped      = 1'b1;
      end
      tick();
      bus.read_en = 1'b0;
      bus.DRTS    = 1'b0;
      q.push_back(flit_t'(32'h20 + i));
      if (popped) void'(q.pop_front());
      else        exp_cnt++;
      n_checks++;
      if (bus.count !== 3'(exp_cnt)) begin
        n_fail++;
        $display("FAIL wrap_count[%0d]: got %0d required %0d", i, bus.count, exp_cnt);
      end
      tick();
    end
    while (q.size() > 0) begin
      n_checks++;
      if (bus.Data_out !== q[0]) begin
        n_fail++;
        $display("FAIL wrap_drain: got %h required %h", bus.Data_out, q[0]);
      end
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
      void'(q.pop_front());
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_final: empty=%b count=%0d, required 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_abnormal();
    bus.read_en = 1'b1;
    tick();
    tick();
    bus.read_en = 1'b0;
    n_checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read: count=%0d empty=%b, required 0 1", bus.count, bus.empty);
    end
    send_flit(32'h0000_0055);
    n_checks++;
    if (bus.Data_out !== 32'h55 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL empty_read_ptr: dout=%h count=%0d, required 00000055 1", bus.Data_out, bus.count);
    end
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    bus.DRTS = 1'b1;
    bus.RX   = 32'h0000_0066;
    tick();
    n_checks++;
    if (bus.CTS !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_cts: got %b required 1", bus.CTS);
    end
    bus.DRTS = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.CTS !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_nowrite: cts=%b count=%0d empty=%b, required 0 0 1", bus.CTS, bus.count, bus.empty);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.DRTS    = 1'b0;
    bus.RX      = '0;
    bus.read_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_single_transfer();
    test_fill_full();
    test_release_full();
    test_wrap_order();
    test_abnormal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
